// File: rtl/alu_funct_pkg.sv
// alu_funct_pkg
//   Shared definitions for the ALU operation sequencer: funct codes,
//   state encodings for the response and multiply FSMs, the default
//   multiplier latency and small funct classification helpers.
package alu_funct_pkg;

    localparam int MUL_CYCLES_DEF = 32;

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_RESP = 1'b1
    } rsp_state_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_RUN  = 2'd1,
        M_WB   = 2'd2
    } mul_state_t;

    function automatic logic funct_is_legal(input logic [5:0] funct);
        logic legal;
        case (funct)
            F_SLL, F_MFHI, F_MFLO, F_MULTU,
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Ops that touch Hi/Lo and therefore must wait for a multiply to retire.
    function automatic logic funct_uses_hilo(input logic [5:0] funct);
        return (funct == F_MULTU) || (funct == F_MFHI) || (funct == F_MFLO);
    endfunction

endpackage

// File: rtl/alu_mul_tracker.sv
// alu_mul_tracker
//   Tracks one in-flight multiply: launches the multiplier, counts its
//   latency and raises the Hi/Lo write strobe when the product is stable.
//
//   state  | meaning
//   M_IDLE | no multiply in flight, counter parked at 0
//   M_RUN  | multiplier computing, counter 0..MUL_CYCLES-1
//   M_WB   | product stable, Hi/Lo written this cycle
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   launch     in   MULTU accepted this cycle
//   mul_start  out  one-cycle multiplier launch pulse
//   mul_busy   out  multiply in flight, including the write-back cycle
//   hilo_we    out  one-cycle Hi/Lo write strobe
module alu_mul_tracker
    import alu_funct_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic launch,
    output logic mul_start,
    output logic mul_busy,
    output logic hilo_we
);

    localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

    mul_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= M_IDLE;
            cnt       <= '0;
            mul_start <= 1'b0;
            mul_busy  <= 1'b0;
            hilo_we   <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                M_IDLE: begin
                    if (launch) begin
                        state     <= M_RUN;
                        cnt       <= '0;
                        mul_start <= 1'b1;
                        mul_busy  <= 1'b1;
                    end
                end
                M_RUN: begin
                    if (cnt == CNT_LAST) begin
                        state   <= M_WB;
                        cnt     <= '0;
                        hilo_we <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                M_WB: begin
                    state    <= M_IDLE;
                    mul_busy <= 1'b0;
                    hilo_we  <= 1'b0;
                end
                default: begin
                    state    <= M_IDLE;
                    cnt      <= '0;
                    mul_busy <= 1'b0;
                    hilo_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Accepts ALU operations from a requester, presents single-cycle results
//   through a valid/ready response port and sequences multi-cycle MULTU
//   against Hi/Lo readers.
//
//   state    | meaning
//   RSP_IDLE | no result presented (rsp_valid=0)
//   RSP_RESP | result presented, held until rsp_ready
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   req_valid    in   requester presents an operation
//   req_funct    in   funct code of the presented operation
//   req_ready    out  operation accepted when req_valid & req_ready
//   op_sel       out  funct driven to ALU, shifter and output mux
//   mul_start    out  one-cycle multiplier launch pulse
//   hilo_we      out  one-cycle Hi/Lo write strobe
//   mul_busy     out  multiply in flight
//   rsp_valid    out  datapath result valid
//   rsp_ready    in   consumer takes the result
//   rsp_illegal  out  result is for an unrecognised funct
module alu_op_sequencer
    import alu_funct_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [5:0] req_funct,
    output logic       req_ready,
    output logic [5:0] op_sel,
    output logic       mul_start,
    output logic       hilo_we,
    output logic       mul_busy,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_illegal
);

    rsp_state_t rsp_state;
    logic       hazard;
    logic       accept;
    logic       accept_mul;
    logic       accept_rsp;
    logic       legal;

    // Hi/Lo users wait out a running multiply so MFHI/MFLO see fresh data.
    assign hazard     = mul_busy && funct_uses_hilo(req_funct);
    assign req_ready  = reset && (!rsp_valid || rsp_ready) && !hazard;
    assign accept     = req_valid && req_ready;
    assign accept_mul = accept && (req_funct == F_MULTU);
    assign accept_rsp = accept && (req_funct != F_MULTU);
    assign legal      = funct_is_legal(req_funct);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_state   <= RSP_IDLE;
            rsp_valid   <= 1'b0;
            rsp_illegal <= 1'b0;
            op_sel      <= '0;
        end else begin
            case (rsp_state)
                RSP_IDLE: begin
                    if (accept_rsp) begin
                        rsp_state   <= RSP_RESP;
                        rsp_valid   <= 1'b1;
                        op_sel      <= legal ? req_funct : 6'd0;
                        rsp_illegal <= !legal;
                    end
                end
                RSP_RESP: begin
                    // Acceptance here implies rsp_ready, so a new op replaces
                    // the old one in the same cycle with no bubble.
                    if (rsp_ready) begin
                        if (accept_rsp) begin
                            rsp_state   <= RSP_RESP;
                            rsp_valid   <= 1'b1;
                            op_sel      <= legal ? req_funct : 6'd0;
                            rsp_illegal <= !legal;
                        end else begin
                            rsp_state <= RSP_IDLE;
                            rsp_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    rsp_state <= RSP_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    alu_mul_tracker #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_tracker (
        .clk       (clk),
        .reset     (reset),
        .launch    (accept_mul),
        .mul_start (mul_start),
        .mul_busy  (mul_busy),
        .hilo_we   (hilo_we)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int MC = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [5:0] req_funct;
    logic       req_ready;
    logic [5:0] op_sel;
    logic       mul_start;
    logic       hilo_we;
    logic       mul_busy;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_illegal;

    alu_op_sequencer #(.MUL_CYCLES(MC)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_funct   (req_funct),
        .req_ready   (req_ready),
        .op_sel      (op_sel),
        .mul_start   (mul_start),
        .hilo_we     (hilo_we),
        .mul_busy    (mul_busy),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_illegal (rsp_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: absolute cycle count, cycle of the last MULTU
    // acceptance, and the response currently owed to the consumer.
    int         cyc;
    int         m_launch;
    bit         m_valid;
    logic [5:0] m_op;
    bit         m_ill;
    bit         last_accept;

    function automatic bit ref_legal(input logic [5:0] f);
        int codes [9] = '{36, 37, 32, 34, 42, 0, 25, 16, 18};
        for (int i = 0; i < 9; i++)
            if (int'(f) == codes[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_hilo(input logic [5:0] f);
        return (f == 6'd25) || (f == 6'd16) || (f == 6'd18);
    endfunction

    function automatic bit ref_busy();
        return (cyc >= m_launch + 1) && (cyc <= m_launch + 1 + MC);
    endfunction

    task automatic model_reset();
        m_launch = -1000;
        m_valid  = 1'b0;
        m_op     = 6'd0;
        m_ill    = 1'b0;
    endtask

    // Drives one cycle from a negedge, compares every output against the
    // model, advances the model at the rising edge and returns at the negedge.
    task automatic drive_cycle(input bit v, input logic [5:0] f, input bit rr);
        bit e_ready;
        bit e_busy;
        req_valid = v;
        req_funct = f;
        rsp_ready = rr;
        #1;
        e_busy  = ref_busy();
        e_ready = (!m_valid || rr) && !(e_busy && ref_hilo(f));
        checks++;
        if (req_ready !== e_ready)
            $display("FAIL req_ready cyc=%0d funct=%0d: got %b expected %b", cyc, f, req_ready, e_ready);
        else passed++;
        checks++;
        if (rsp_valid !== m_valid)
            $display("FAIL rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid, m_valid);
        else passed++;
        if (m_valid) begin
            checks++;
            if (op_sel !== m_op)
                $display("FAIL op_sel cyc=%0d: got %0d expected %0d", cyc, op_sel, m_op);
            else passed++;
            checks++;
            if (rsp_illegal !== m_ill)
                $display("FAIL rsp_illegal cyc=%0d: got %b expected %b", cyc, rsp_illegal, m_ill);
            else passed++;
        end
        checks++;
        if (mul_start !== (cyc == m_launch + 1))
            $display("FAIL mul_start cyc=%0d: got %b expected %b", cyc, mul_start, cyc == m_launch + 1);
        else passed++;
        checks++;
        if (mul_busy !== e_busy)
            $display("FAIL mul_busy cyc=%0d: got %b expected %b", cyc, mul_busy, e_busy);
        else passed++;
        checks++;
        if (hilo_we !== (cyc == m_launch + 1 + MC))
            $display("FAIL hilo_we cyc=%0d: got %b expected %b", cyc, hilo_we, cyc == m_launch + 1 + MC);
        else passed++;
        last_accept = v && e_ready;
        @(posedge clk);
        if (m_valid && rr) m_valid = 1'b0;
        if (last_accept) begin
            if (f == 6'd25) begin
                m_launch = cyc;
            end else begin
                m_valid = 1'b1;
                m_ill   = !ref_legal(f);
                m_op    = m_ill ? 6'd0 : f;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b1;
        req_funct = 6'd32;
        rsp_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_illegal, mul_start, hilo_we, mul_busy, req_ready} !== 6'b0 || op_sel !== 6'd0)
            $display("FAIL reset_outputs: got v=%b ill=%b st=%b we=%b busy=%b rdy=%b op=%0d expected all 0",
                     rsp_valid, rsp_illegal, mul_start, hilo_we, mul_busy, req_ready, op_sel);
        else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || mul_start !== 1'b0)
            $display("FAIL reset_held: got v=%b rdy=%b st=%b expected 0 0 0", rsp_valid, req_ready, mul_start);
        else passed++;
        reset = 1'b1;
        cyc   = 0;
        model_reset();
        drive_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_add();
        drive_cycle(1'b1, 6'd32, 1'b1);
        checks++;
        if (rsp_valid !== 1'b1 || op_sel !== 6'd32)
            $display("FAIL add_resp: got v=%b op=%0d expected 1 32", rsp_valid, op_sel);
        else passed++;
        drive_cycle(1'b0, 6'd0, 1'b1);
        checks++;
        if (rsp_valid !== 1'b0)
            $display("FAIL add_drop: got v=%b expected 0", rsp_valid);
        else passed++;
    endtask

    task automatic test_multu_mfhi();
        int c0;
        int acc_at;
        int we_pulses;
        c0        = cyc;
        acc_at    = -1;
        we_pulses = 0;
        drive_cycle(1'b1, 6'd25, 1'b1);
        checks++;
        if (mul_start !== 1'b1 || mul_busy !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL multu_launch: got st=%b busy=%b v=%b expected 1 1 0", mul_start, mul_busy, rsp_valid);
        else passed++;
        drive_cycle(1'b0, 6'd0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            int at;
            at = cyc;
            drive_cycle(1'b1, 6'd16, 1'b1);
            if (hilo_we === 1'b1) we_pulses++;
            if (last_accept) begin
                acc_at = at - c0;
                break;
            end
        end
        checks++;
        if (acc_at != MC + 2)
            $display("FAIL mfhi_accept_cycle: got %0d expected %0d", acc_at, MC + 2);
        else passed++;
        checks++;
        if (rsp_valid !== 1'b1 || op_sel !== 6'd16 || mul_busy !== 1'b0)
            $display("FAIL mfhi_resp: got v=%b op=%0d busy=%b expected 1 16 0", rsp_valid, op_sel, mul_busy);
        else passed++;
        checks++;
        if (we_pulses != 1)
            $display("FAIL hilo_we_pulses: got %0d expected 1", we_pulses);
        else passed++;
        drive_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_stall();
        drive_cycle(1'b1, 6'd34, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 6'd36, 1'b0);
            checks++;
            if (op_sel !== 6'd34 || rsp_valid !== 1'b1 || last_accept)
                $display("FAIL sub_hold_%0d: got op=%0d v=%b acc=%b expected 34 1 0", i, op_sel, rsp_valid, last_accept);
            else passed++;
        end
        drive_cycle(1'b1, 6'd36, 1'b1);
        checks++;
        if (!last_accept || op_sel !== 6'd36 || rsp_valid !== 1'b1)
            $display("FAIL and_after_handshake: got acc=%b op=%0d v=%b expected 1 36 1", last_accept, op_sel, rsp_valid);
        else passed++;
        drive_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_illegal();
        drive_cycle(1'b1, 6'd63, 1'b1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || op_sel !== 6'd0)
            $display("FAIL illegal_resp: got v=%b ill=%b op=%0d expected 1 1 0", rsp_valid, rsp_illegal, op_sel);
        else passed++;
        drive_cycle(1'b1, 6'd37, 1'b1);
        checks++;
        if (rsp_illegal !== 1'b0 || op_sel !== 6'd37)
            $display("FAIL illegal_clear: got ill=%b op=%0d expected 0 37", rsp_illegal, op_sel);
        else passed++;
        drive_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq [6] = '{6'd32, 6'd37, 6'd36, 6'd0, 6'd42, 6'd34};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, seq[i], 1'b1);
            checks++;
            if (!last_accept || op_sel !== seq[i] || rsp_valid !== 1'b1)
                $display("FAIL b2b_%0d: got acc=%b op=%0d v=%b expected 1 %0d 1", i, last_accept, op_sel, rsp_valid, seq[i]);
            else passed++;
        end
        drive_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_overlap();
        drive_cycle(1'b1, 6'd25, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, (i % 2 == 0) ? 6'd32 : 6'd42, 1'b1);
            checks++;
            if (!last_accept || mul_busy !== 1'b1)
                $display("FAIL overlap_%0d: got acc=%b busy=%b expected 1 1", i, last_accept, mul_busy);
            else passed++;
        end
        drive_cycle(1'b1, 6'd25, 1'b1);
        checks++;
        if (last_accept)
            $display("FAIL multu_hazard: got acc=1 expected 0");
        else passed++;
        for (int i = 0; i < MC; i++) drive_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_reset_mid_mul();
        drive_cycle(1'b1, 6'd25, 1'b1);
        repeat (9) drive_cycle(1'b0, 6'd0, 1'b1);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mul_busy !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || op_sel !== 6'd0)
            $display("FAIL reset_mid_mul: got busy=%b rdy=%b v=%b op=%0d expected 0 0 0 0",
                     mul_busy, req_ready, rsp_valid, op_sel);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        cyc += 3;
        req_valid = 1'b1;
        req_funct = 6'd25;
        #1;
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL ready_after_release: got %b expected 1", req_ready);
        else passed++;
        // Run past where the aborted multiply would have written back.
        for (int i = 0; i < MC; i++) drive_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_random();
        logic [5:0] pool [12] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0,
                                  6'd25, 6'd25, 6'd16, 6'd18, 6'd63, 6'd5};
        for (int i = 0; i < 400; i++)
            drive_cycle($urandom_range(0, 3) != 0, pool[$urandom_range(0, 11)], $urandom_range(0, 3) != 0);
        for (int i = 0; i < MC + 4; i++) drive_cycle(1'b0, 6'd0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_multu_mfhi();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_overlap();
        test_reset_mid_mul();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
